// File: rtl/clk_gate_ctrl.sv
// Enable generator for the clock-gating stage: closes the gated domain after an idle window, reopens it on Req/Force_On.
// Gate_En rises one edge after a wake sample; Ack follows WAKE_CYCLES edges later; every output is a flop.
module clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8,
  parameter int OFF_CNT_W   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Req,
  input  logic                 Busy,
  input  logic                 Force_On,
  output logic                 Gate_En,
  output logic                 Ack,
  output logic [1:0]           State,
  output logic [OFF_CNT_W-1:0] Off_Count
);

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_WAKE  = 2'd1;
  localparam logic [1:0] S_ON    = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES - 1);

  if (IDLE_CYCLES < 1 || IDLE_CYCLES > (2 ** CNT_W)) begin : g_bad_idle
    $fatal(1, "clk_gate_ctrl: IDLE_CYCLES out of range 1..2^CNT_W");
  end
  if (WAKE_CYCLES < 1 || WAKE_CYCLES > (2 ** CNT_W)) begin : g_bad_wake
    $fatal(1, "clk_gate_ctrl: WAKE_CYCLES out of range 1..2^CNT_W");
  end

  logic             act;
  logic             wake;
  logic [CNT_W-1:0] cnt;

  assign act  = Req | Busy | Force_On;
  assign wake = Req | Force_On;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      State     <= S_OFF;
      Gate_En   <= 1'b0;
      Ack       <= 1'b0;
      cnt       <= '0;
      Off_Count <= '0;
    end else begin
      case (State)
        S_OFF: begin
          if (wake) begin
            State   <= S_WAKE;
            Gate_En <= 1'b1;
            cnt     <= WAKE_LD;
          end
        end
        // A Req dropped mid-wake still completes the wake; Ack then simply stays low.
        S_WAKE: begin
          if (cnt == '0) begin
            State <= S_ON;
            Ack   <= Req;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_ON: begin
          if (!act) begin
            State <= S_DRAIN;
            Ack   <= 1'b0;
            cnt   <= IDLE_LD;
          end else begin
            Ack <= Req;
          end
        end
        default: begin
          // Activity wins over an expiring idle count so the gate never drops under load.
          if (act) begin
            State <= S_ON;
            Ack   <= Req;
          end else if (cnt == '0) begin
            State   <= S_OFF;
            Gate_En <= 1'b0;
            if (Off_Count != '1) Off_Count <= Off_Count + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule
